// File: rtl/svmwin_score.sv
// Sums each WINCOLS-column detection window of the SVM partial-product stream plus bias and thresholds it.
// Optional SVMWIN_SATURATE_EN: clamp the window sum to 32 bits instead of wrapping.
module svmwin_score #(
  parameter int                 WINCOLS = 8,
  parameter int                 WPI     = 40,
  parameter logic signed [31:0] BIAS    = 0,
  parameter logic signed [31:0] THRESH  = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [31:0]             svm_data,
  input  logic                    dvi,
  output logic [31:0]             score,
  output logic                    detect,
  output logic [$clog2(WPI)-1:0]  win_index,
  output logic                    dvo,
  output logic                    row_done,
  output logic                    err
);
  localparam int CW = $clog2(WINCOLS);
  localparam int WW = $clog2(WPI);
  localparam int AW = 32 + CW + 1;

  typedef enum logic {IDLE, ACC} state_t;

  state_t                state, state_nx;
  logic [CW-1:0]         col;
  logic [WW-1:0]         win, win_cur;
  logic signed [AW-1:0]  acc, acc_base, data_ext, sum;
  logic [31:0]           sum_red;
  logic                  last_col, last_win;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (dvi)  state_nx = ACC;
      ACC:     if (!dvi) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // A word arriving in IDLE opens a burst, which always starts at window 0
  assign win_cur  = (state == IDLE) ? '0 : win;
  assign last_col = (col == CW'(WINCOLS - 1));
  assign last_win = (win_cur == WW'(WPI - 1));
  assign acc_base = (col == '0) ? {{(AW-32){BIAS[31]}}, BIAS} : acc;
  assign data_ext = {{(AW-32){svm_data[31]}}, svm_data};
  assign sum      = acc_base + data_ext;

`ifdef SVMWIN_SATURATE_EN
  localparam logic signed [AW-1:0] SAT_HI = {{(AW-31){1'b0}}, {31{1'b1}}};
  localparam logic signed [AW-1:0] SAT_LO = {{(AW-31){1'b1}}, {31{1'b0}}};
  always_comb begin
    sum_red = sum[31:0];
    if (sum > SAT_HI)      sum_red = 32'h7fff_ffff;
    else if (sum < SAT_LO) sum_red = 32'h8000_0000;
  end
`else
  assign sum_red = sum[31:0];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      col       <= '0;
      win       <= '0;
      acc       <= '0;
      score     <= '0;
      detect    <= 1'b0;
      win_index <= '0;
      dvo       <= 1'b0;
      row_done  <= 1'b0;
      err       <= 1'b0;
    end else begin
      state    <= state_nx;
      dvo      <= 1'b0;
      row_done <= 1'b0;
      err      <= 1'b0;
      if (dvi) begin
        if (last_col) begin
          col       <= '0;
          acc       <= sum;
          score     <= sum_red;
          detect    <= ($signed(sum_red) > THRESH);
          win_index <= win_cur;
          dvo       <= 1'b1;
          row_done  <= last_win;
          win       <= last_win ? '0 : win_cur + WW'(1);
        end else begin
          col <= col + CW'(1);
          acc <= sum;
          win <= win_cur;
        end
      end else begin
        // Burst ended: a partially accumulated window is dropped and flagged
        err <= (col != '0);
        col <= '0;
        acc <= '0;
      end
    end
  end
endmodule

// File: tb/tb_svmwin_score.sv
// Randomized self-checking bench for svmwin_score against a window-sum reference model.
module tb_svmwin_score;
  localparam int WC  = 8;
  localparam int WPI = 40;
  localparam int WW  = $clog2(WPI);
  localparam logic signed [31:0] BIAS   = -10;
  localparam logic signed [31:0] THRESH = 100;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          dvi = 1'b0;
  logic [31:0]   svm_data = '0;
  logic [31:0]   score;
  logic          detect;
  logic [WW-1:0] win_index;
  logic          dvo, row_done, err;

  svmwin_score #(.WINCOLS(WC), .WPI(WPI), .BIAS(BIAS), .THRESH(THRESH)) dut (
    .clk(clk), .reset(reset), .svm_data(svm_data), .dvi(dvi),
    .score(score), .detect(detect), .win_index(win_index),
    .dvo(dvo), .row_done(row_done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]   score;
    logic          detect;
    logic [WW-1:0] win;
    logic          dvo, row, err;
  } obs_t;

  obs_t        obs[$];
  logic [31:0] stim[$];
  int          checks = 0;
  int          errors = 0;

  // Exact window sum ending at word i of the current burst
  function automatic longint exact(int i);
    longint s = longint'(BIAS);
    for (int j = i - WC + 1; j <= i; j++) s += longint'($signed(stim[j]));
    return s;
  endfunction

  function automatic logic [31:0] reduce(longint s);
`ifdef SVMWIN_SATURATE_EN
    longint hi = (longint'(1) << 31) - 1;
    longint lo = -(longint'(1) << 31);
    if (s > hi) return 32'h7fff_ffff;
    if (s < lo) return 32'h8000_0000;
`endif
    return s[31:0];
  endfunction

  function automatic logic exp_det(logic [31:0] r);
    return $signed(r) > THRESH;
  endfunction

  task automatic step(input logic v, input logic [31:0] d, input logic r);
    obs_t o;
    dvi = v; svm_data = d; reset = r;
    @(posedge clk); #1;
    o.score = score; o.detect = detect; o.win = win_index;
    o.dvo = dvo; o.row = row_done; o.err = err;
    obs.push_back(o);
  endtask

  // mode 0: constant val, 1: random, 2: counting 1,2,3...; one idle cycle follows
  task automatic burst(input int n, input int mode, input logic [31:0] val);
    logic [31:0] w;
    stim.delete(); obs.delete();
    for (int i = 0; i < n; i++) begin
      case (mode)
        0:       w = val;
        1:       w = $urandom;
        default: w = i + 1;
      endcase
      stim.push_back(w);
      step(1'b1, w, 1'b0);
    end
    step(1'b0, '0, 1'b0);
  endtask

  task automatic test_reset();
    obs.delete();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, $urandom, 1'b1);
      checks++;
      if ({obs[i].score, obs[i].detect, obs[i].win, obs[i].dvo, obs[i].row, obs[i].err} !== '0) begin
        errors++;
        $display("FAIL reset: score=%h det=%b win=%0d dvo=%b row=%b err=%b want all 0",
                 obs[i].score, obs[i].detect, obs[i].win, obs[i].dvo, obs[i].row, obs[i].err);
      end
    end
  endtask

  task automatic test_single();
    logic [31:0] e;
    burst(8, 2, '0);
    for (int i = 0; i <= 8; i++) begin
      checks++;
      if (obs[i].dvo !== (i == 7)) begin
        errors++; $display("FAIL single_dvo[%0d]: got %b want %b", i, obs[i].dvo, i == 7);
      end
    end
    e = reduce(exact(7));
    checks++;
    if (obs[7].score !== e || obs[7].detect !== exp_det(e) || obs[7].win !== '0) begin
      errors++;
      $display("FAIL single: score=%0d det=%b win=%0d want %0d %b 0",
               $signed(obs[7].score), obs[7].detect, obs[7].win, $signed(e), exp_det(e));
    end
    checks++;
    if (obs[8].err !== 1'b0) begin
      errors++; $display("FAIL single_err: got %b want 0", obs[8].err);
    end
  endtask

  task automatic test_row();
    int pulses = 0;
    logic [31:0] e;
    burst(WC * WPI, 0, 32'd20);
    for (int i = 0; i < WC * WPI; i++) begin
      checks++;
      if (obs[i].dvo !== (i % WC == WC - 1)) begin
        errors++; $display("FAIL row_dvo[%0d]: got %b want %b", i, obs[i].dvo, i % WC == WC - 1);
      end
      if (i % WC == WC - 1) begin
        pulses++;
        e = reduce(exact(i));
        checks++;
        if (obs[i].score !== e || obs[i].detect !== exp_det(e) || obs[i].win !== WW'(i / WC)
            || obs[i].row !== (i / WC == WPI - 1)) begin
          errors++;
          $display("FAIL row[%0d]: score=%0d det=%b win=%0d row=%b want %0d %b %0d %b", i,
                   $signed(obs[i].score), obs[i].detect, obs[i].win, obs[i].row,
                   $signed(e), exp_det(e), i / WC, i / WC == WPI - 1);
        end
      end else begin
        checks++;
        if (obs[i].row !== 1'b0) begin
          errors++; $display("FAIL row_done_stray[%0d]: got 1 want 0", i);
        end
      end
    end
    checks++;
    if (pulses != WPI || obs[WC * WPI].err !== 1'b0) begin
      errors++; $display("FAIL row_count: pulses=%0d err=%b want %0d 0", pulses, obs[WC * WPI].err, WPI);
    end
  endtask

  task automatic test_wrap();
    int n = WC * WPI + WC;
    logic [31:0] e;
    burst(n, 1, '0);
    checks++;
    if (obs[WC * WPI - 1].row !== 1'b1 || obs[WC * WPI - 1].win !== WW'(WPI - 1)) begin
      errors++; $display("FAIL wrap_row: row=%b win=%0d want 1 %0d",
                         obs[WC * WPI - 1].row, obs[WC * WPI - 1].win, WPI - 1);
    end
    e = reduce(exact(n - 1));
    checks++;
    if (obs[n - 1].dvo !== 1'b1 || obs[n - 1].win !== '0 || obs[n - 1].row !== 1'b0
        || obs[n - 1].score !== e) begin
      errors++; $display("FAIL wrap_next: dvo=%b win=%0d row=%b score=%h want 1 0 0 %h",
                         obs[n - 1].dvo, obs[n - 1].win, obs[n - 1].row, obs[n - 1].score, e);
    end
  endtask

  task automatic test_err();
    logic [31:0] e;
    burst(3, 1, '0);
    step(1'b0, '0, 1'b0);
    for (int i = 0; i <= 4; i++) begin
      checks++;
      if (obs[i].dvo !== 1'b0 || obs[i].err !== (i == 3)) begin
        errors++; $display("FAIL err[%0d]: dvo=%b err=%b want 0 %b", i, obs[i].dvo, obs[i].err, i == 3);
      end
    end
    burst(8, 1, '0);
    e = reduce(exact(7));
    checks++;
    if (obs[7].dvo !== 1'b1 || obs[7].win !== '0 || obs[7].score !== e || obs[8].err !== 1'b0) begin
      errors++; $display("FAIL err_recover: dvo=%b win=%0d score=%h err=%b want 1 0 %h 0",
                         obs[7].dvo, obs[7].win, obs[7].score, obs[8].err, e);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] e;
    burst(8, 0, 32'h7fff_fff0);
    e = reduce(exact(7));
    checks++;
    if (obs[7].score !== e || obs[7].detect !== exp_det(e)) begin
      errors++; $display("FAIL ovf_pos: score=%h det=%b want %h %b", obs[7].score, obs[7].detect, e, exp_det(e));
    end
`ifdef SVMWIN_SATURATE_EN
    checks++;
    if (obs[7].score !== 32'h7fff_ffff || obs[7].detect !== 1'b1) begin
      errors++; $display("FAIL ovf_sat: score=%h det=%b want 7fffffff 1", obs[7].score, obs[7].detect);
    end
`endif
    burst(8, 0, 32'h8000_0000);
    e = reduce(exact(7));
    checks++;
    if (obs[7].score !== e || obs[7].detect !== exp_det(e)) begin
      errors++; $display("FAIL ovf_neg: score=%h det=%b want %h %b", obs[7].score, obs[7].detect, e, exp_det(e));
    end
  endtask

  task automatic test_back_to_back();
    burst(16, 1, '0);
    checks++;
    if (obs[7].win !== WW'(0) || obs[15].win !== WW'(1) || obs[15].score !== reduce(exact(15))
        || obs[16].err !== 1'b0) begin
      errors++; $display("FAIL b2b: win=%0d,%0d score=%h err=%b want 0,1 %h 0",
                         obs[7].win, obs[15].win, obs[15].score, obs[16].err, reduce(exact(15)));
    end
    burst(8, 1, '0);
    checks++;
    if (obs[7].dvo !== 1'b1 || obs[7].win !== '0) begin
      errors++; $display("FAIL b2b_restart: dvo=%b win=%0d want 1 0", obs[7].dvo, obs[7].win);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] w;
    stim.delete(); obs.delete();
    for (int i = 0; i < 2 * WC + 5; i++) step(1'b1, $urandom, 1'b0);
    step(1'b1, $urandom, 1'b1);
    checks++;
    if ({obs[$].score, obs[$].detect, obs[$].win, obs[$].dvo, obs[$].row, obs[$].err} !== '0) begin
      errors++; $display("FAIL reset_mid: score=%h win=%0d dvo=%b want 0 0 0", obs[$].score, obs[$].win, obs[$].dvo);
    end
    stim.delete(); obs.delete();
    for (int i = 0; i < WC; i++) begin
      w = $urandom; stim.push_back(w); step(1'b1, w, 1'b0);
    end
    step(1'b0, '0, 1'b0);
    for (int i = 0; i < WC - 1; i++) begin
      checks++;
      if (obs[i].dvo !== 1'b0) begin
        errors++; $display("FAIL reset_mid_early[%0d]: dvo=1 want 0", i);
      end
    end
    checks++;
    if (obs[7].dvo !== 1'b1 || obs[7].win !== '0 || obs[7].score !== reduce(exact(7))) begin
      errors++; $display("FAIL reset_mid_after: dvo=%b win=%0d score=%h want 1 0 %h",
                         obs[7].dvo, obs[7].win, obs[7].score, reduce(exact(7)));
    end
  endtask

  task automatic test_random();
    int n, le;
    logic [31:0] e;
    for (int b = 0; b < 6; b++) begin
      n = $urandom_range(1, 120);
      burst(n, 1, '0);
      for (int i = 0; i < n; i++) begin
        checks++;
        if (obs[i].dvo !== (i % WC == WC - 1)) begin
          errors++; $display("FAIL rnd_dvo[%0d]: got %b want %b", i, obs[i].dvo, i % WC == WC - 1);
        end
        // After the first window, outputs carry the most recent completed window
        le = (i % WC == WC - 1) ? i : (i / WC) * WC - 1;
        if (le >= 0) begin
          e = reduce(exact(le));
          checks++;
          if (obs[i].score !== e || obs[i].detect !== exp_det(e) || obs[i].win !== WW'((le / WC) % WPI)
              || obs[i].row !== (i == le && (le / WC) % WPI == WPI - 1)) begin
            errors++;
            $display("FAIL rnd[%0d]: score=%h det=%b win=%0d row=%b want %h %b %0d", i,
                     obs[i].score, obs[i].detect, obs[i].win, obs[i].row, e, exp_det(e), (le / WC) % WPI);
          end
        end
      end
      checks++;
      if (obs[n].err !== (n % WC != 0) || obs[n].dvo !== 1'b0) begin
        errors++; $display("FAIL rnd_end(n=%0d): err=%b dvo=%b want %b 0", n, obs[n].err, obs[n].dvo, n % WC != 0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_row();
    test_wrap();
    test_err();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/svmwin_score.md
# svmwin_score

Window scoring stage behind the SVM row-slice memory. Consumes the downloaded stream of signed 32-bit per-column partial dot products, adds the WINCOLS column sums of each detection window plus a bias, and compares the total against a threshold. Emits one score and detect flag per window, with window index and end-of-row markers, to the detection/NMS stage.

## Interface
Parameters:
- WINCOLS, 8, column partial sums per window (power of two, ≥2)
- WPI, 40, windows per image row
- BIAS, 0, signed 32-bit bias added to every window sum
- THRESH, 0, signed 32-bit decision threshold

Ports (clock, reset first):
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- svm_data  in  32  signed column partial sum, valid when dvi=1
- dvi  in  1  data valid; driven by the upstream download dvo, high for the whole burst
- score  out  32  signed window score (bias included)
- detect  out  1  score > THRESH (signed compare)
- win_index  out  $clog2(WPI)  index of the scored window within the row
- dvo  out  1  one-cycle strobe, score/detect/win_index valid
- row_done  out  1  one-cycle strobe coincident with dvo of window WPI-1
- err  out  1  one-cycle strobe, burst ended mid-window

## Operation
- FSM states IDLE, ACC.
  - IDLE→ACC on dvi=1.
  - ACC→IDLE on dvi=0.
- Every rising edge of dvi (IDLE with dvi=1) clears win counter to 0: each burst starts at window 0.
- col counter (0..WINCOLS-1) advances on each cycle with dvi=1 and wraps to 0 after WINCOLS-1.
- Accumulator, width 32+$clog2(WINCOLS)+1 bits, signed:
  - col==0: acc ← sign-extended BIAS + svm_data.
  - Otherwise: acc ← acc + svm_data.
  - No intermediate overflow is possible at this width.
- On the word with col==WINCOLS-1, the final sum (acc + svm_data) is reduced to 32 bits (see Configuration) and registered into score. The same cycle also registers:
  - detect = (reduced score > THRESH)
  - win_index = win counter
  - dvo = 1
- The win counter then increments.
- At win==WPI-1 completion: row_done=1 with dvo, and the win counter wraps to 0. Further words in the same burst start a new row at window 0.
- dvi falls (ACC→IDLE) with col≠0:
  - err=1 for one cycle.
  - col cleared and partial sum discarded; no dvo for that window.
- dvi falls with col==0: no err, clean end.
- Between bursts, col and acc hold reset values; win is cleared at the next burst start.
- Reset asserted mid-burst:
  - Next cycle: all outputs 0, FSM IDLE, counters 0, acc 0.
  - Words present while reset=1 are ignored.
  - If dvi is still high after reset deasserts, the first dvi=1 cycle after reset is treated as a burst start with col=0.

## Timing
- Reset values: score=0, detect=0, win_index=0, dvo=0, row_done=0, err=0.
- Latency: last column word on cycle t → dvo/score/detect/win_index/row_done at cycle t+1, all registered.
- dvo, row_done, err are single-cycle pulses.
- score, detect, win_index hold until the next dvo.
- err is asserted in the cycle after the first dvi=0 cycle.
- Back-to-back throughput: one window per WINCOLS cycles, no bubbles required. dvo may occur every WINCOLS cycles.
- dvi may drop and return between windows (col==0) without error; the win counter restarts at 0 on return.

## Configuration
- SVMWIN_SATURATE_EN:
  - Defined: final sum clamped to [-2^31, 2^31-1] before the compare and the score register.
  - Undefined: low 32 bits kept (two's-complement wrap). The compare uses the wrapped value.

## Test plan
- Single window, WINCOLS=8, BIAS=-10, THRESH=100, data 1..8 back-to-back → one dvo one cycle after the 8th word; score=26, detect=0, win_index=0, err=0.
- Full row, WPI=40, constant data 20, BIAS=0, THRESH=159 → 40 dvo pulses spaced 8 cycles apart; score=160, detect=1, win_index 0..39; row_done only with win_index=39.
- Burst of 8*40+8 words → row_done at window 39, then a further dvo with win_index=0 (wrap).
- Burst of 3 words then dvi=0 → err pulse one cycle after dvi falls, no dvo. The next full window in a new burst scores correctly with win_index=0.
- Overflow case: 8 words of 0x7FFFFFF0, BIAS=0x100:
  - With SVMWIN_SATURATE_EN → score=0x7FFFFFFF, detect=1.
  - Without it → score equals the low 32 bits of the exact sum.
- Reset asserted at column 5 of window 2 → outputs 0 next cycle. After release with dvi high, the following 8 words produce win_index=0 and a correct score.
